// File: rtl/calc_pkg.sv
// Shared types, widths and the ALU evaluation function for the calc port responder.
package calc_pkg;

  localparam int DATA_W = 32;
  localparam int N_PORTS = 4;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    OK   = 2'b01,
    ERR  = 2'b10,
    BAD  = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_OP2 = 2'd1,
    PEND    = 2'd2,
    RESP    = 2'd3
  } port_state_e;

  typedef struct packed {
    resp_e             resp;
    logic [DATA_W-1:0] data;
  } alu_res_t;

  // Pure function of one command's cmd/op1/op2; data is forced to 0 unless resp is OK.
  function automatic alu_res_t alu_eval(input logic [3:0]        cmd,
                                        input logic [DATA_W-1:0] op1,
                                        input logic [DATA_W-1:0] op2);
    alu_res_t        res;
    logic [DATA_W:0] sum;
    res.resp = BAD;
    res.data = '0;
    sum      = {1'b0, op1} + {1'b0, op2};
    case (cmd)
      ADD: begin
        if (sum[DATA_W]) res.resp = ERR;
        else begin
          res.resp = OK;
          res.data = sum[DATA_W-1:0];
        end
      end
      SUB: begin
        if (op1 < op2) res.resp = ERR;
        else begin
          res.resp = OK;
          res.data = op1 - op2;
        end
      end
      SHL: begin
        res.resp = OK;
        res.data = op1 << op2[4:0];
      end
      SHR: begin
        res.resp = OK;
        res.data = op1 >> op2[4:0];
      end
      default: begin
        res.resp = BAD;
        res.data = '0;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calc_port_fsm.sv
// Per-port capture FSM: takes cmd+op1, then op2, waits for a grant, holds RESP one cycle.
module calc_port_fsm
  import calc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        cmd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              grant_i,
  output logic              pend_o,
  output logic [3:0]        cmd_o,
  output logic [DATA_W-1:0] op1_o,
  output logic [DATA_W-1:0] op2_o
);

  port_state_e       state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;

  // State and captured operands; reset discards any in-flight command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

  // Next state; commands arriving outside IDLE (including RESP) are dropped.
  always_comb begin
    // NOTE: hold-value defaults first so no path leaves a signal unassigned (no latches).
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    case (state_q)
      IDLE: begin
        if (cmd_i != NOP) begin
          cmd_d   = cmd_i;
          op1_d   = data_i;
          state_d = GET_OP2;
        end
      end
      GET_OP2: begin
        op2_d   = data_i;
        state_d = PEND;
      end
      PEND: begin
        if (grant_i) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pend_o = (state_q == PEND);
  assign cmd_o  = cmd_q;
  assign op1_o  = op1_q;
  assign op2_o  = op2_q;

endmodule

// File: rtl/calc_port_responder.sv
// Four-port calculator: per-port capture FSMs share one ALU through a round-robin arbiter.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter int DATA_W = 32  // only 32 is supported
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [DATA_W-1:0] out_data1,
  output logic [1:0]        out_resp2,
  output logic [DATA_W-1:0] out_data2,
  output logic [1:0]        out_resp3,
  output logic [DATA_W-1:0] out_data3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data4
);

  logic [3:0]        cmd_in   [N_PORTS];
  logic [DATA_W-1:0] data_in  [N_PORTS];
  logic [3:0]        port_cmd [N_PORTS];
  logic [DATA_W-1:0] port_op1 [N_PORTS];
  logic [DATA_W-1:0] port_op2 [N_PORTS];
  logic [N_PORTS-1:0] pend;
  logic [N_PORTS-1:0] grant;

  logic [1:0]        ptr_q, ptr_d;   // highest-priority port this cycle
  logic [1:0]        gnt_idx, scan_idx;
  logic              gnt_vld;
  alu_res_t          alu_res;

  logic [1:0]        resp_q [N_PORTS];
  logic [DATA_W-1:0] data_q [N_PORTS];

  assign cmd_in[0] = req1_cmd_in;  assign data_in[0] = req1_data_in;
  assign cmd_in[1] = req2_cmd_in;  assign data_in[1] = req2_data_in;
  assign cmd_in[2] = req3_cmd_in;  assign data_in[2] = req3_data_in;
  assign cmd_in[3] = req4_cmd_in;  assign data_in[3] = req4_data_in;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_port
    calc_port_fsm u_fsm (
      .clk_i   (c_clk),
      .rst_ni  (reset),
      .cmd_i   (cmd_in[k]),
      .data_i  (data_in[k]),
      .grant_i (grant[k]),
      .pend_o  (pend[k]),
      .cmd_o   (port_cmd[k]),
      .op1_o   (port_op1[k]),
      .op2_o   (port_op2[k])
    );
  end

  // Round-robin pick: scan from ptr_q upward, first pending port wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!gnt_vld && pend[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    grant   = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
    ptr_d   = gnt_vld ? gnt_idx + 2'd1 : ptr_q;
    alu_res = alu_eval(port_cmd[gnt_idx], port_op1[gnt_idx], port_op2[gnt_idx]);
  end

  // Arbiter pointer and registered per-port responses (non-granted ports read zero).
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      for (int k = 0; k < N_PORTS; k++) begin
        resp_q[k] <= NONE;
        data_q[k] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int k = 0; k < N_PORTS; k++) begin
        resp_q[k] <= grant[k] ? alu_res.resp : NONE;
        data_q[k] <= grant[k] ? alu_res.data : '0;
      end
    end
  end

  assign out_resp1 = resp_q[0];  assign out_data1 = data_q[0];
  assign out_resp2 = resp_q[1];  assign out_data2 = data_q[1];
  assign out_resp3 = resp_q[2];  assign out_data3 = data_q[2];
  assign out_resp4 = resp_q[3];  assign out_data4 = data_q[3];

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder: ALU results, arbitration order, drops and reset.
module tb_calc_port_responder;
  import calc_pkg::*;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cmd    [4];
  logic [31:0] dat    [4];
  logic [1:0]  resp_w [4];
  logic [31:0] data_w [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 c_clk = ~c_clk;

  calc_port_responder #(.DATA_W(32)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd[0]), .req1_data_in (dat[0]),
    .req2_cmd_in  (cmd[1]), .req2_data_in (dat[1]),
    .req3_cmd_in  (cmd[2]), .req3_data_in (dat[2]),
    .req4_cmd_in  (cmd[3]), .req4_data_in (dat[3]),
    .out_resp1    (resp_w[0]), .out_data1 (data_w[0]),
    .out_resp2    (resp_w[1]), .out_data2 (data_w[1]),
    .out_resp3    (resp_w[2]), .out_data3 (data_w[2]),
    .out_resp4    (resp_w[3]), .out_data4 (data_w[3])
  );

  // Advance to the sampling point of the next cycle (#1 after the rising edge).
  task automatic next_cycle();
    @(posedge c_clk);
    #1;
  endtask

  // Drive a command in cycle N on every port in mask, op2 in N+1; returns at cycle N+2.
  task automatic issue(input logic [3:0] mask, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 4; k++) if (mask[k]) begin cmd[k] = c; dat[k] = a; end
    next_cycle();
    for (int k = 0; k < 4; k++) if (mask[k]) begin cmd[k] = 4'd0; dat[k] = b; end
    next_cycle();
    for (int k = 0; k < 4; k++) dat[k] = 32'd0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin cmd[k] = 4'd0; dat[k] = 32'd0; end
    reset = 1'b0;
    repeat (3) @(posedge c_clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (resp_w[k] !== 2'b00 || data_w[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset port%0d: got resp=%b data=%h, want 00/0", k + 1, resp_w[k], data_w[k]);
      end
    end
    @(negedge c_clk);
    reset = 1'b1;
    @(posedge c_clk);
    #1;
  endtask

  // One command on one port: nothing at N+2, exact result at N+3, silence again at N+4.
  task automatic test_single_port(input string name, input int p, input logic [3:0] c,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] er, input logic [31:0] ed);
    logic [1:0]  exp_r;
    logic [31:0] exp_d;
    issue(4'b0001 << p, c, a, b);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (resp_w[k] !== 2'b00) begin
        n_fail++;
        $display("FAIL %s early port%0d: got resp=%b at N+2, want 00", name, k + 1, resp_w[k]);
      end
    end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      exp_r = (k == p) ? er : 2'b00;
      exp_d = (k == p) ? ed : 32'd0;
      n_checks++;
      if (resp_w[k] !== exp_r || data_w[k] !== exp_d) begin
        n_fail++;
        $display("FAIL %s port%0d: got resp=%b data=%h, want resp=%b data=%h",
                 name, k + 1, resp_w[k], data_w[k], exp_r, exp_d);
      end
    end
    next_cycle();
    n_checks++;
    if (resp_w[p] !== 2'b00 || data_w[p] !== 32'd0) begin
      n_fail++;
      $display("FAIL %s hold port%0d: got resp=%b data=%h at N+4, want 00/0",
               name, p + 1, resp_w[p], data_w[p]);
    end
  endtask

  // All four ports issue add 1+1 together; responses follow the given grant order.
  task automatic test_back_to_back(input string name, input int o0, input int o1,
                                   input int o2, input int o3);
    int order [4];
    order = '{o0, o1, o2, o3};
    issue(4'hF, ADD, 32'd1, 32'd1);
    for (int j = 0; j < 4; j++) begin
      next_cycle();
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (k == order[j]) begin
          if (resp_w[k] !== 2'b01 || data_w[k] !== 32'd2) begin
            n_fail++;
            $display("FAIL %s N+%0d port%0d: got resp=%b data=%h, want 01/2",
                     name, j + 3, k + 1, resp_w[k], data_w[k]);
          end
        end else if (resp_w[k] !== 2'b00) begin
          n_fail++;
          $display("FAIL %s N+%0d port%0d: got resp=%b, want 00", name, j + 3, k + 1, resp_w[k]);
        end
      end
    end
    next_cycle();
  endtask

  // Commands presented while in PEND and in RESP are dropped: exactly one response.
  task automatic test_drop();
    issue(4'b0001, ADD, 32'h10, 32'h20);
    cmd[0] = ADD; dat[0] = 32'h100;      // port 1 is in PEND
    next_cycle();
    n_checks++;
    if (resp_w[0] !== 2'b01 || data_w[0] !== 32'h30) begin
      n_fail++;
      $display("FAIL drop first: got resp=%b data=%h, want 01/00000030", resp_w[0], data_w[0]);
    end
    cmd[0] = SUB; dat[0] = 32'h200;      // port 1 is in RESP
    next_cycle();
    cmd[0] = 4'd0; dat[0] = 32'd0;
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (resp_w[0] !== 2'b00) begin
        n_fail++;
        $display("FAIL drop extra N+%0d: got resp=%b data=%h, want 00", j + 4, resp_w[0], data_w[0]);
      end
      next_cycle();
    end
  endtask

  // Reset pulsed while port 1 is in PEND: the command vanishes, then a fresh add works.
  task automatic test_reset_mid();
    issue(4'b0001, ADD, 32'h7, 32'h8);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    for (int j = 0; j < 5; j++) begin
      next_cycle();
      n_checks++;
      if (resp_w[0] !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_mid N+%0d: got resp=%b data=%h, want 00", j + 3, resp_w[0], data_w[0]);
      end
    end
    test_single_port("reset_mid_new", 0, ADD, 32'h2, 32'h3, 2'b01, 32'h5);
  endtask

  initial begin
    test_reset();
    test_back_to_back("all4_after_reset", 0, 1, 2, 3);
    test_single_port("add_p1",       0, ADD, 32'h64,       32'h27, 2'b01, 32'h8B);
    test_single_port("add_ovf_p2",   1, ADD, 32'hFFFFFFFF, 32'h1,  2'b10, 32'h0);
    test_single_port("sub_unf_p3",   2, SUB, 32'h22,       32'h23, 2'b10, 32'h0);
    test_single_port("sub_p4",       3, SUB, 32'h5,        32'h2,  2'b01, 32'h3);
    test_single_port("add_max_p1",   0, ADD, 32'hFFFFFFFE, 32'h1,  2'b01, 32'hFFFFFFFF);
    test_single_port("sub_eq_p2",    1, SUB, 32'h5,        32'h5,  2'b01, 32'h0);
    test_single_port("shl_p3",       2, SHL, 32'h3,        32'h2,  2'b01, 32'hC);
    test_single_port("shr_p4",       3, SHR, 32'hC,        32'h2,  2'b01, 32'h3);
    test_single_port("shl_wrap_p1",  0, SHL, 32'h1,        32'h21, 2'b01, 32'h2);
    test_single_port("shl_zero_p2",  1, SHL, 32'hA5,       32'h20, 2'b01, 32'hA5);
    test_single_port("shr_msb_p3",   2, SHR, 32'h80000000, 32'h1F, 2'b01, 32'h1);
    test_single_port("bad7_p4",      3, 4'h7, 32'h1234,    32'h1,  2'b11, 32'h0);
    test_single_port("badF_p1",      0, 4'hF, 32'hFFFF,    32'hFF, 2'b11, 32'h0);
    test_drop();
    test_single_port("rot_seed_p2",  1, ADD, 32'h1,        32'h2,  2'b01, 32'h3);
    test_back_to_back("all4_rotated", 2, 3, 0, 1);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
